// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I datapath: fetch, decode, exec,
// memory and write-back sequencing with ack timeouts and a retire counter.
module mc_ctrl_fsm #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ir,
  output logic [2:0]       imm_type,
  output logic             alu_src_b,
  input  logic             br_cond,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_BAD, OP_ALI, OP_LOAD, OP_STORE, OP_BR, OP_JALR, OP_JAL, OP_LUI
  } op_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LIMIT = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state, next;
  op_t             op;
  logic [2:0]      imm_dec;
  logic [TW-1:0]   wait_cnt;
  logic            timeout;
  logic            retire;
  logic            set_illegal;
  logic            set_bus_err;

  always_comb begin
    op = OP_BAD;
    case (ir[6:0])
      7'b0010011: op = OP_ALI;
      7'b0000011: op = OP_LOAD;
      7'b0100011: op = OP_STORE;
      7'b1100011: op = OP_BR;
      7'b1100111: op = OP_JALR;
      7'b1101111: op = OP_JAL;
      7'b0110111: op = OP_LUI;
      default:    op = OP_BAD;
    endcase
  end

  always_comb begin
    imm_dec = 3'd0;
    case (op)
      OP_ALI:           imm_dec = (ir[13:12] == 2'b01) ? 3'd6 : 3'd1;
      OP_LOAD, OP_JALR: imm_dec = 3'd1;
      OP_STORE:         imm_dec = 3'd2;
      OP_BR:            imm_dec = 3'd3;
      OP_LUI:           imm_dec = 3'd4;
      OP_JAL:           imm_dec = 3'd5;
      default:          imm_dec = 3'd0;
    endcase
  end

  // Limit reached only matters when no ack arrives that same cycle.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);

  always_comb begin
    next        = state;
    imem_req    = 1'b0;
    imm_type    = 3'd0;
    alu_src_b   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          next = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          next        = S_HALT;
        end
      end
      S_DECODE: begin
        imm_type = imm_dec;
        if (op == OP_BAD) begin
          set_illegal = 1'b1;
          next        = S_HALT;
        end else begin
          next = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_type  = imm_dec;
        alu_src_b = (op != OP_BR);
        case (op)
          OP_BR: begin
            pc_we  = 1'b1;
            pc_sel = br_cond ? 2'd1 : 2'd0;
            retire = 1'b1;
            next   = S_FETCH;
          end
          OP_LOAD, OP_STORE: next = S_MEM;
          default:           next = S_WB;
        endcase
      end
      S_MEM: begin
        imm_type  = imm_dec;
        alu_src_b = 1'b1;
        dmem_req  = 1'b1;
        dmem_we   = (op == OP_STORE);
        if (dmem_ack) begin
          if (op == OP_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            next   = S_FETCH;
          end else begin
            next = S_WB;
          end
        end else if (timeout) begin
          set_bus_err = 1'b1;
          next        = S_HALT;
        end
      end
      S_WB: begin
        imm_type  = imm_dec;
        alu_src_b = 1'b1;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        next      = S_FETCH;
        case (op)
          OP_LOAD: wb_sel = 2'd1;
          OP_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
          OP_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
          default: wb_sel = 2'd0;
        endcase
      end
      default: next = S_HALT;
    endcase
    // Reset forces every strobe low immediately, even mid-access.
    if (rst) begin
      imem_req  = 1'b0;
      imm_type  = 3'd0;
      alu_src_b = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= WIDTH'(32'h0000_0013);
      instr_cnt <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (next != state) wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
